// File: rtl/aes_pkg.sv
// AES-128 shared definitions and GF(2^8) helpers
// for the iterative decryption datapath.
package aes_pkg;
  localparam int AES_BLOCK_W   = 128;
  localparam int AES_KEY_W     = 128;
  localparam int AES128_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b,
    input int         n
  );
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = a;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2)
      ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] a
  );
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3)
      ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon_at(
    input int j
  );
    logic [7:0] r;
    r = 8'h01;
    for (int k = 2; k <= 10; k++)
      if (k <= j) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          gmul(a[r], 8'h0e)
          ^ gmul(a[(r+1)%4], 8'h0b)
          ^ gmul(a[(r+2)%4], 8'h0d)
          ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Walks the key schedule one step backwards
  function automatic logic [127:0] inv_key_step(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96]
      ^ sub_word({p3[23:0], p3[31:24]})
      ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction
endpackage

// File: rtl/aes_dec_iter_ctrl_decround.sv
// One AES-128 decryption round plus one backward
// key-schedule step; round 1 skips InvMixColumns.
module DECround
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_W    = 4
) (
  input  logic [AES_BLOCK_W-1:0] i_state,
  input  logic [AES_KEY_W-1:0]   i_key,
  input  logic [ROUND_W-1:0]     i_round,
  output logic [AES_BLOCK_W-1:0] o_nextstate,
  output logic [AES_KEY_W-1:0]   o_nextkey,
  output logic [ROUND_W-1:0]     o_nextround
);
  logic [AES_BLOCK_W-1:0] w_imc;
  logic [AES_BLOCK_W-1:0] w_isr;
  logic [AES_BLOCK_W-1:0] w_isb;
  logic [7:0]             w_rcon;

  // Round r consumes K(11-r) and yields K(10-r)
  always_comb begin
    w_imc = (i_round == ROUND_W'(1))
      ? i_state : inv_mix_columns(i_state);
    w_isr = inv_shift_rows(w_imc);
    w_isb = inv_sub_bytes(w_isr);
    w_rcon = rcon_at(NUM_ROUNDS + 1 - int'(i_round));
    o_nextkey = inv_key_step(i_key, w_rcon);
    o_nextstate = w_isb ^ o_nextkey;
    o_nextround = i_round + ROUND_W'(1);
  end
endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption sequencer: one
// shared DECround fed back on itself for 10 rounds.
module aes_dec_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic [AES_KEY_W-1:0]   in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);
  fsm_e                   fsm_q, fsm_d;
  logic [AES_BLOCK_W-1:0] state_q, state_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;
  logic [ROUND_W-1:0]     round_q, round_d;

  logic [AES_BLOCK_W-1:0] w_nextstate;
  logic [AES_KEY_W-1:0]   w_nextkey;
  logic [ROUND_W-1:0]     w_nextround;
  logic                   w_round_ok;
  logic                   w_last;

  DECround #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round (
    .i_state     (state_q),
    .i_key       (key_q),
    .i_round     (round_q),
    .o_nextstate (w_nextstate),
    .o_nextkey   (w_nextkey),
    .o_nextround (w_nextround)
  );

  assign w_round_ok = (round_q != '0)
    && (int'(round_q) <= NUM_ROUNDS);
  assign w_last = (round_q == ROUND_W'(NUM_ROUNDS));

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          round_d = ROUND_W'(1);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (!w_round_ok) begin
          round_d = '0;
          fsm_d   = IDLE;
        end else begin
          state_d = w_nextstate;
          key_d   = w_nextkey;
          // Counter saturates on the last round
          if (w_last) fsm_d = DONE;
          else round_d = w_nextround;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE) && !reset;
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
  assign out_data  = state_q;
endmodule
